// File: rtl/flippy_pkg.sv
// rtl/flippy_pkg.sv - shared clock/debounce constants for the flippy board front end
package flippy_pkg;

  localparam int CLK_HZ                  = 50_000_000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 1000 * DEBOUNCE_MS;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser and debounce counter for one input bit
module debounce_bit
  import flippy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit BYPASS          = 1'b0
) (
  input  logic clock,
  input  logic reset_signal,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic change
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic          stable_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          cur_level;
  logic          nxt_level;

  // Accept s2 only after it has differed from stable for DEBOUNCE_CYCLES
  // consecutive edges; any agreement in between clears the count. With
  // BYPASS set the counter and stable register hold at 0 and fall away.
  always_comb begin
    stable_next = stable;
    cnt_next    = '0;
    if (!BYPASS && (s2 != stable)) begin
      if (cnt == CNT_LAST) begin
        stable_next = s2;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  // In bypass the visible level is s2 itself, so edges are detected on s1 -> s2.
  always_comb begin
    cur_level = BYPASS ? s2 : stable;
    nxt_level = BYPASS ? s1 : stable_next;
  end

  // Synchroniser, debounce state and edge pulses, all registered on one edge.
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
      change <= 1'b0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      stable <= stable_next;
      cnt    <= cnt_next;
      rise   <= ~cur_level & nxt_level;
      change <= cur_level ^ nxt_level;
    end
  end

  assign level = cur_level;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise and debounce board switches/buttons (INPUT_COND_SW_DEBOUNCE_EN enables switch debounce)
module input_conditioner
  import flippy_pkg::*;
#(
  parameter int SW_WIDTH        = 8,
  parameter int BTN_WIDTH       = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic                 clock,
  input  logic                 reset_signal,
  input  logic [SW_WIDTH-1:0]  sw_raw,
  input  logic [BTN_WIDTH-1:0] button_raw,
  output logic [SW_WIDTH-1:0]  sw_stable,
  output logic                 sw_changed,
  output logic [BTN_WIDTH-1:0] btn_level,
  output logic [BTN_WIDTH-1:0] btn_press
);

`ifdef INPUT_COND_SW_DEBOUNCE_EN
  localparam bit SW_BYPASS = 1'b0;
`else
  localparam bit SW_BYPASS = 1'b1;
`endif

  logic [BTN_WIDTH-1:0] btn_in;
  logic [BTN_WIDTH-1:0] btn_change;
  logic [SW_WIDTH-1:0]  sw_rise;
  logic [SW_WIDTH-1:0]  sw_change;
  logic                 unused_bits;

  // Normalise buttons so everything downstream treats 1 as pressed.
  always_comb begin
    btn_in = (BTN_ACTIVE_LOW != 0) ? ~button_raw : button_raw;
  end

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BYPASS          (SW_BYPASS)
    ) u_sw (
      .clock        (clock),
      .reset_signal (reset_signal),
      .raw          (sw_raw[i]),
      .level        (sw_stable[i]),
      .rise         (sw_rise[i]),
      .change       (sw_change[i])
    );
  end

  for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BYPASS          (1'b0)
    ) u_btn (
      .clock        (clock),
      .reset_signal (reset_signal),
      .raw          (btn_in[i]),
      .level        (btn_level[i]),
      .rise         (btn_press[i]),
      .change       (btn_change[i])
    );
  end

  // Per-bit change flags are already registered; merging them yields one pulse
  // even when several switches settle on the same edge.
  always_comb begin
    sw_changed  = |sw_change;
    unused_bits = ^{sw_rise, btn_change};
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - randomized and directed bench for input_conditioner against a run-length model
module tb_input_conditioner;

  localparam int D   = 4;
  localparam int SWW = 8;
  localparam int BW  = 3;
  localparam int NB  = SWW + BW;

`ifdef INPUT_COND_SW_DEBOUNCE_EN
  localparam bit SW_DEB = 1'b1;
`else
  localparam bit SW_DEB = 1'b0;
`endif
  localparam int SW_LAT = SW_DEB ? D + 2 : 2;

  logic           clock = 1'b0;
  logic           reset_signal;
  logic [SWW-1:0] sw_raw;
  logic [BW-1:0]  button_raw;
  logic [SWW-1:0] sw_stable;
  logic           sw_changed;
  logic [BW-1:0]  btn_level;
  logic [BW-1:0]  btn_press;

  int checks = 0;
  int errors = 0;

  input_conditioner #(
    .SW_WIDTH        (SWW),
    .BTN_WIDTH       (BW),
    .DEBOUNCE_CYCLES (D),
    .BTN_ACTIVE_LOW  (1)
  ) dut (
    .clock        (clock),
    .reset_signal (reset_signal),
    .sw_raw       (sw_raw),
    .button_raw   (button_raw),
    .sw_stable    (sw_stable),
    .sw_changed   (sw_changed),
    .btn_level    (btn_level),
    .btn_press    (btn_press)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each input reaches the debouncer two edges late; a bit is
  // accepted once it has disagreed with the accepted value for D edges in a row.
  logic [NB-1:0]  m_d1, m_d2, m_acc;
  int             m_run [NB];
  logic [BW-1:0]  m_press;
  logic [SWW-1:0] m_sw_out;
  logic           m_changed;

  always @(posedge clock) begin
    logic [NB-1:0]  seen, nxt;
    logic [SWW-1:0] sw_now;
    if (reset_signal) begin
      m_d1 = '0; m_d2 = '0; m_acc = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      m_press = '0; m_sw_out = '0; m_changed = 1'b0;
    end else begin
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = {~button_raw, sw_raw};
      nxt  = m_acc;
      for (int i = 0; i < NB; i++) begin
        if (i >= SWW || SW_DEB) begin
          if (seen[i] != m_acc[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == D) begin
              nxt[i]   = seen[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_press   = ~m_acc[NB-1:SWW] & nxt[NB-1:SWW];
      sw_now    = SW_DEB ? nxt[SWW-1:0] : m_d2[SWW-1:0];
      m_changed = (sw_now != m_sw_out);
      m_sw_out  = sw_now;
      m_acc     = nxt;
    end
  end

  bit model_on = 1'b0;

  // Every cycle, away from the clock edge, the DUT must agree with the model.
  always @(negedge clock) begin
    if (model_on) begin
      check("m_sw_stable", 32'(sw_stable), 32'(m_sw_out));
      check("m_sw_changed", 32'(sw_changed), 32'(m_changed));
      check("m_btn_level", 32'(btn_level), 32'(m_acc[NB-1:SWW]));
      check("m_btn_press", 32'(btn_press), 32'(m_press));
    end
  end

  initial begin
    int n_press, n_chg, n_trans;
    logic prev3;

    reset_signal = 1'b1;
    button_raw   = 3'b111;
    sw_raw       = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_outputs", 32'({sw_stable, sw_changed, btn_level, btn_press}), 32'd0);
    model_on     = 1'b1;
    reset_signal = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("idle_zero", 32'({sw_stable, sw_changed, btn_level, btn_press}), 32'd0);
    end

    // Single button press: level and one press pulse after D+2 edges.
    button_raw[0] = 1'b0;
    repeat (5) @(negedge clock);
    check("b0_level_e5", 32'(btn_level), 32'd0);
    @(negedge clock);
    check("b0_level_e6", 32'(btn_level), 32'b001);
    check("b0_press_e6", 32'(btn_press), 32'b001);
    @(negedge clock);
    check("b0_press_e7", 32'(btn_press), 32'b000);
    check("b0_level_e7", 32'(btn_level), 32'b001);
    button_raw[0] = 1'b1;
    repeat (12) @(negedge clock);
    check("b0_released", 32'(btn_level), 32'd0);

    // Glitch of D-1 cycles is rejected; D cycles is accepted.
    n_press = 0;
    button_raw[1] = 1'b0;
    repeat (3) @(negedge clock);
    button_raw[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (btn_level[1] || btn_press[1]) n_press++;
    end
    check("b1_short_glitch", 32'(n_press), 32'd0);
    n_press = 0;
    button_raw[1] = 1'b0;
    repeat (4) @(negedge clock);
    button_raw[1] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      if (btn_press[1]) n_press++;
    end
    check("b1_min_accept", 32'(n_press), 32'd1);

    // All switches move together: one change pulse.
    n_chg = 0;
    sw_raw = 8'hA5;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (sw_changed) n_chg++;
      if (i == SW_LAT - 1) check("sw_a5_early", 32'(sw_stable), 32'h00);
      if (i == SW_LAT) check("sw_a5_lat", 32'(sw_stable), 32'hA5);
    end
    check("sw_a5_pulses", 32'(n_chg), 32'd1);

    sw_raw = 8'h00;
    repeat (12) @(negedge clock);
    check("sw_cleared", 32'(sw_stable), 32'h00);

    // Bounce on one switch.
    n_chg = 0; n_trans = 0; prev3 = sw_stable[3];
    for (int i = 0; i < 18; i++) begin
      sw_raw[3] = (i == 1 || i >= 3) ? 1'b1 : 1'b0;
      @(negedge clock);
      if (sw_changed) n_chg++;
      if (sw_stable[3] != prev3) n_trans++;
      prev3 = sw_stable[3];
    end
    check("bounce_pulses", 32'(n_chg), SW_DEB ? 32'd1 : 32'd3);
    check("bounce_trans", 32'(n_trans), SW_DEB ? 32'd1 : 32'd3);
    check("bounce_final", 32'(sw_stable), 32'h08);

    // Reset in the middle of a count, button held throughout.
    button_raw[2] = 1'b0;
    repeat (2) @(negedge clock);
    reset_signal = 1'b1;
    @(negedge clock);
    check("rst_mid_lvl_a", 32'(btn_level), 32'd0);
    @(negedge clock);
    check("rst_mid_lvl_b", 32'(btn_level), 32'd0);
    reset_signal = 1'b0;
    repeat (5) @(negedge clock);
    check("rst_rel_e5", 32'(btn_level[2]), 32'd0);
    @(negedge clock);
    check("rst_rel_e6_lvl", 32'(btn_level), 32'b100);
    check("rst_rel_e6_press", 32'(btn_press), 32'b100);
    @(negedge clock);
    check("rst_rel_e7_press", 32'(btn_press), 32'b000);
    button_raw = 3'b111;
    repeat (10) @(negedge clock);

    // Random slow-changing inputs with occasional resets; model checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5, 0) == 0) sw_raw[$urandom_range(SWW - 1, 0)] ^= 1'b1;
      if ($urandom_range(5, 0) == 0) button_raw[$urandom_range(BW - 1, 0)] ^= 1'b1;
      reset_signal = ($urandom_range(150, 0) == 0);
      @(negedge clock);
    end
    reset_signal = 1'b0;
    repeat (4) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
